processing_unit: RTL and testbench

LC-3 datapath execution core: an 8 x 16-bit general-purpose register file, SR1/SR2/DR address steering, and a 16-bit ALU. It sits between the control FSM (which drives `ld_reg`, `aluk`, and the mux selects) and the shared system bus. It receives write-back data from the bus and sources ALU results to the bus through the top-level bus gate (GateALU).

---
 rtl/lc3_pkg.sv | 35 +++
 rtl/reg_file.sv | 39 +++
 rtl/processing_unit.sv | 80 ++++++++
 tb/tb_processing_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: word/register-address typedefs, ALU and address-mux
// encodings, and the imm5 sign-extension helper.
package lc3_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_addr_t;

    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_NOT   = 2'b10,
        ALU_PASSA = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        SR1_IR11_9   = 2'b00,
        SR1_IR8_6    = 2'b01,
        SR1_R6       = 2'b10,
        SR1_IR8_6_B  = 2'b11
    } sr1mux_e;

    typedef enum logic [1:0] {
        DR_IR11_9    = 2'b00,
        DR_R7        = 2'b01,
        DR_R6        = 2'b10,
        DR_IR11_9_B  = 2'b11
    } drmux_e;

    function automatic word_t sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8 x 16-bit register file: one synchronous write port, two combinational read
// ports without write-to-read bypass, asynchronous active-low clear.
module reg_file
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [2:0]  wrAddr_i,
    input  logic [15:0] wrData_i,
    input  logic [2:0]  rdAddrA_i,
    output logic [15:0] rdDataA_o,
    input  logic [2:0]  rdAddrB_i,
    output logic [15:0] rdDataB_o
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[wrAddr_i] = wrData_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see only committed state, so a same-cycle write shows up after the edge.
    assign rdDataA_o = regs_q[rdAddrA_i];
    assign rdDataB_o = regs_q[rdAddrB_i];

endmodule

// File: rtl/processing_unit.sv
// LC-3 execution core: register-address steering, operand-B selection and the
// 16-bit ALU around an 8-entry register file.
module processing_unit
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_reg,
    input  logic [1:0]  aluk,
    input  logic [2:0]  ir_11_9,
    input  logic [2:0]  ir_8_6,
    input  logic [2:0]  ir_2_0,
    input  logic [1:0]  sr1mux,
    input  logic [1:0]  drmux,
    input  logic        ir_5,
    input  logic [4:0]  ir_4_0,
    input  logic [15:0] from_bus,
    output logic [15:0] sr1_out,
    output logic [15:0] to_bus
);

    reg_addr_t sr1Addr;
    reg_addr_t drAddr;
    word_t     srcA;
    word_t     sr2Data;
    word_t     srcB;
    word_t     aluResult;

    always_comb begin
        sr1Addr = ir_8_6;
        case (sr1mux_e'(sr1mux))
            SR1_IR11_9:  sr1Addr = ir_11_9;
            SR1_IR8_6:   sr1Addr = ir_8_6;
            SR1_R6:      sr1Addr = 3'd6;
            SR1_IR8_6_B: sr1Addr = ir_8_6;
            default:     sr1Addr = ir_8_6;
        endcase
    end

    always_comb begin
        drAddr = ir_11_9;
        case (drmux_e'(drmux))
            DR_IR11_9:   drAddr = ir_11_9;
            DR_R7:       drAddr = 3'd7;
            DR_R6:       drAddr = 3'd6;
            DR_IR11_9_B: drAddr = ir_11_9;
            default:     drAddr = ir_11_9;
        endcase
    end

    // from_bus only feeds the write port, so looping to_bus back is combinationally safe.
    reg_file u_regFile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (ld_reg),
        .wrAddr_i  (drAddr),
        .wrData_i  (from_bus),
        .rdAddrA_i (sr1Addr),
        .rdDataA_o (srcA),
        .rdAddrB_i (ir_2_0),
        .rdDataB_o (sr2Data)
    );

    assign srcB = ir_5 ? sext5(ir_4_0) : sr2Data;

    always_comb begin
        aluResult = srcA;
        case (aluk_e'(aluk))
            ALU_ADD:   aluResult = srcA + srcB;
            ALU_AND:   aluResult = srcA & srcB;
            ALU_NOT:   aluResult = ~srcA;
            ALU_PASSA: aluResult = srcA;
            default:   aluResult = srcA;
        endcase
    end

    assign sr1_out = srcA;
    assign to_bus  = aluResult;

endmodule

// File: tb/tb_processing_unit.sv
// Scoreboard bench for processing_unit: directed LC-3 sequences plus random ops,
// checked against an array-based architectural model of the register file.
module tb_processing_unit;

    logic        clk;
    logic        reset;
    logic        ld_reg;
    logic [1:0]  aluk;
    logic [2:0]  ir_11_9;
    logic [2:0]  ir_8_6;
    logic [2:0]  ir_2_0;
    logic [1:0]  sr1mux;
    logic [1:0]  drmux;
    logic        ir_5;
    logic [4:0]  ir_4_0;
    logic [15:0] from_bus;
    logic [15:0] sr1_out;
    logic [15:0] to_bus;

    logic        loopBack;
    logic [15:0] busData;

    int          modelRegs [8];
    logic [15:0] expBusQ [$];
    logic [15:0] expSr1Q [$];
    string       labelQ [$];
    event        checkEv;
    int          checkCount = 0;
    int          passCount = 0;

    processing_unit dut (
        .clk      (clk),
        .reset    (reset),
        .ld_reg   (ld_reg),
        .aluk     (aluk),
        .ir_11_9  (ir_11_9),
        .ir_8_6   (ir_8_6),
        .ir_2_0   (ir_2_0),
        .sr1mux   (sr1mux),
        .drmux    (drmux),
        .ir_5     (ir_5),
        .ir_4_0   (ir_4_0),
        .from_bus (from_bus),
        .sr1_out  (sr1_out),
        .to_bus   (to_bus)
    );

    assign from_bus = loopBack ? to_bus : busData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Monitor: each issued stimulus is checked 1 time unit later, well before the next edge.
    initial begin
        forever begin
            @(checkEv);
            #1;
            if (expBusQ.size() > 0) begin
                string lbl;
                lbl = labelQ.pop_front();
                checkOutput({lbl, ".to_bus"}, to_bus, expBusQ.pop_front());
                checkOutput({lbl, ".sr1_out"}, sr1_out, expSr1Q.pop_front());
            end
        end
    end

    // Drives one operation, predicts outputs from the model and, if written, the new register state.
    task automatic applyStimulus(input string name, input logic [1:0] op, input int dr, input int sr1,
                                 input int sr2, input logic [1:0] s1m, input logic [1:0] dm,
                                 input logic useImm, input int imm, input logic ld,
                                 input logic loop, input int busVal);
        int a, b, res, sr1Idx, drIdx, immVal;
        aluk    = op;
        ir_11_9 = 3'(dr);
        ir_8_6  = 3'(sr1);
        ir_2_0  = 3'(sr2);
        sr1mux  = s1m;
        drmux   = dm;
        ir_5    = useImm;
        ir_4_0  = 5'(imm);
        ld_reg  = ld;
        loopBack = loop;
        busData = 16'(busVal);

        sr1Idx = (s1m == 2'b00) ? (dr % 8) : (s1m == 2'b10) ? 6 : (sr1 % 8);
        drIdx  = (dm == 2'b01) ? 7 : (dm == 2'b10) ? 6 : (dr % 8);
        immVal = imm % 32;
        if (immVal >= 16) immVal = immVal - 32;
        a = modelRegs[sr1Idx];
        b = useImm ? ((immVal + 65536) % 65536) : modelRegs[sr2 % 8];
        case (op)
            2'b00:   res = (a + b) % 65536;
            2'b01:   res = a & b;
            2'b10:   res = 65535 - a;
            default: res = a;
        endcase

        expBusQ.push_back(16'(res));
        expSr1Q.push_back(16'(a));
        labelQ.push_back(name);
        ->checkEv;
        if (ld && reset) begin
            modelRegs[drIdx] = loop ? res : (busVal % 65536);
        end
        #2;
    endtask

    task automatic step(input string name, input logic [1:0] op, input int dr, input int sr1,
                        input int sr2, input logic useImm, input int imm, input logic ld,
                        input logic loop, input int busVal);
        @(negedge clk);
        applyStimulus(name, op, dr, sr1, sr2, 2'b01, 2'b00, useImm, imm, ld, loop, busVal);
    endtask

    task automatic writeReg(input int r, input int value);
        step("write", 2'b11, r, 0, 0, 1'b0, 0, 1'b1, 1'b0, value);
    endtask

    task automatic readAll(input string name);
        for (int r = 0; r < 8; r++) begin
            step(name, 2'b11, 0, r, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        ld_reg = 1'b0; aluk = 2'b00; ir_11_9 = '0; ir_8_6 = '0; ir_2_0 = '0;
        sr1mux = '0; drmux = '0; ir_5 = 1'b0; ir_4_0 = '0; loopBack = 1'b0; busData = '0;
        for (int r = 0; r < 8; r++) modelRegs[r] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        readAll("reset");

        writeReg(7, 16'h000F);
        writeReg(4, 16'h00F0);
        step("passR7", 2'b11, 0, 7, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        step("passR4", 2'b11, 0, 4, 0, 1'b0, 0, 1'b0, 1'b0, 0);

        writeReg(1, 3);
        writeReg(2, 4);
        step("addR3", 2'b00, 3, 1, 2, 1'b0, 0, 1'b1, 1'b1, 0);
        step("addR4", 2'b00, 4, 1, 3, 1'b0, 0, 1'b1, 1'b1, 0);
        step("addR7", 2'b00, 7, 4, 3, 1'b0, 0, 1'b1, 1'b1, 0);
        readAll("chain");

        step("immR0", 2'b00, 0, 2, 0, 1'b1, 8, 1'b1, 1'b1, 0);
        step("immR1", 2'b00, 1, 1, 0, 1'b1, 8, 1'b1, 1'b1, 0);
        step("immNeg", 2'b00, 0, 1, 0, 1'b1, 5'h1F, 1'b0, 1'b1, 0);
        readAll("imm");

        writeReg(5, 16'h00F0);
        writeReg(6, 16'h000F);
        step("and", 2'b01, 0, 5, 6, 1'b0, 0, 1'b0, 1'b0, 0);
        step("not", 2'b10, 0, 6, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        writeReg(5, 16'hFFFF);
        step("wrap", 2'b00, 0, 5, 0, 1'b1, 1, 1'b0, 1'b0, 0);

        @(negedge clk);
        applyStimulus("drR7", 2'b11, 2, 0, 0, 2'b00, 2'b01, 1'b0, 0, 1'b1, 1'b0, 16'h1234);
        @(negedge clk);
        applyStimulus("drR6", 2'b11, 2, 0, 0, 2'b00, 2'b10, 1'b0, 0, 1'b1, 1'b0, 16'h5A5A);
        @(negedge clk);
        applyStimulus("sr1R6", 2'b11, 1, 3, 0, 2'b10, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0);
        readAll("muxes");

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            applyStimulus("rand", 2'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)),
                          int'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                          1'($urandom_range(1)), int'($urandom_range(31)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), int'($urandom_range(65535)));
        end

        // Asynchronous clear mid-cycle, with a write attempted while reset is held.
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int r = 0; r < 8; r++) modelRegs[r] = 0;
        readAll("asyncRst");
        @(negedge clk);
        applyStimulus("rstWrite", 2'b11, 3, 3, 0, 2'b01, 2'b00, 1'b0, 0, 1'b1, 1'b0, 16'hBEEF);
        @(negedge clk);
        ld_reg = 1'b0;
        reset = 1'b1;
        readAll("postRst");

        for (int w = 0; w < 10 && expBusQ.size() > 0; w++) @(negedge clk);
        if (expBusQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expBusQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
